// File: rtl/hex_keypad_scanner_pkg.sv
// Purpose: shared keypad constants, FSM state encoding and decode helpers for the keypad scanner.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package hex_keypad_scanner_pkg;

  localparam int KP_ROWS = 4;
  localparam int KP_COLS = 4;

  typedef enum logic [1:0] {
    KP_SCAN     = 2'd0,
    KP_DEBOUNCE = 2'd1,
    KP_HELD     = 2'd2
  } kp_state_e;

  // Key legend by row / column; '*' reads as E and '#' reads as F.
  localparam logic [3:0] KEY_R0_C0 = 4'h1;
  localparam logic [3:0] KEY_R0_C1 = 4'h2;
  localparam logic [3:0] KEY_R0_C2 = 4'h3;
  localparam logic [3:0] KEY_R0_C3 = 4'hA;
  localparam logic [3:0] KEY_R1_C0 = 4'h4;
  localparam logic [3:0] KEY_R1_C1 = 4'h5;
  localparam logic [3:0] KEY_R1_C2 = 4'h6;
  localparam logic [3:0] KEY_R1_C3 = 4'hB;
  localparam logic [3:0] KEY_R2_C0 = 4'h7;
  localparam logic [3:0] KEY_R2_C1 = 4'h8;
  localparam logic [3:0] KEY_R2_C2 = 4'h9;
  localparam logic [3:0] KEY_R2_C3 = 4'hC;
  localparam logic [3:0] KEY_R3_C0 = 4'hE;
  localparam logic [3:0] KEY_R3_C1 = 4'h0;
  localparam logic [3:0] KEY_R3_C2 = 4'hF;
  localparam logic [3:0] KEY_R3_C3 = 4'hD;

  function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    code = 4'h0;
    case ({row, col})
      4'h0: code = KEY_R0_C0;
      4'h1: code = KEY_R0_C1;
      4'h2: code = KEY_R0_C2;
      4'h3: code = KEY_R0_C3;
      4'h4: code = KEY_R1_C0;
      4'h5: code = KEY_R1_C1;
      4'h6: code = KEY_R1_C2;
      4'h7: code = KEY_R1_C3;
      4'h8: code = KEY_R2_C0;
      4'h9: code = KEY_R2_C1;
      4'hA: code = KEY_R2_C2;
      4'hB: code = KEY_R2_C3;
      4'hC: code = KEY_R3_C0;
      4'hD: code = KEY_R3_C1;
      4'hE: code = KEY_R3_C2;
      default: code = KEY_R3_C3;
    endcase
    return code;
  endfunction

  // A usable pattern has exactly one row pulled low; anything else is idle or ghosting.
  function automatic logic one_low(input logic [3:0] rows);
    return (rows == 4'b1110) || (rows == 4'b1101) || (rows == 4'b1011) || (rows == 4'b0111);
  endfunction

  function automatic logic [1:0] low_index(input logic [3:0] rows);
    logic [1:0] idx;
    idx = 2'd0;
    case (rows)
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/hex_keypad_scanner_sync_2ff.sv
// Purpose: generic two-flop synchroniser for asynchronous active-low inputs.
// Latency: two clock cycles from input change to output.
// Backpressure: none; resets to all-ones so idle active-low lines read inactive.
module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  // Next values simply shift the input one stage per clock.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Both stages return to the inactive (all-ones) level on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/hex_keypad_scanner.sv
// Purpose: scans a 4x4 active-low keypad, debounces presses and shifts accepted hex digits into a 16-bit entry register.
// Latency: key_valid pulses one cycle after the DEBOUNCE_TICKS-th consecutive stable tick (rows pass a 2-cycle synchroniser first).
// Backpressure: none; key_valid is a one-cycle pulse and key_code / entry_value hold until the next accept.
module hex_keypad_scanner
  import hex_keypad_scanner_pkg::*;
#(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_TICKS = 10
) (
  input  logic               clk100MHz,
  input  logic               rst,
  input  logic [KP_ROWS-1:0] row_in,
  input  logic               entry_clr,
  output logic [KP_COLS-1:0] col_out,
  output logic               key_valid,
  output logic [3:0]         key_code,
  output logic               key_held,
  output logic [15:0]        entry_value
);

  localparam int TICK_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DB_W   = $clog2(DEBOUNCE_TICKS + 1);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCAN_DIV - 1);
  localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
  localparam logic [DB_W-1:0]   DB_DONE   = DB_W'(DEBOUNCE_TICKS);
  localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);

  logic [KP_ROWS-1:0] rs;
  logic               tick;
  logic [DB_W-1:0]    dbc_inc;
  logic               accept;

  logic [TICK_W-1:0]  tick_cnt_q, tick_cnt_d;
  kp_state_e          state_q, state_d;
  logic [1:0]         col_q, col_d;
  logic [3:0]         pat_q, pat_d;
  logic [DB_W-1:0]    dbc_q, dbc_d;
  logic               key_valid_q, key_valid_d;
  logic [3:0]         key_code_q, key_code_d;
  logic               key_held_q, key_held_d;
  logic [15:0]        entry_q, entry_d;

  sync_2ff #(.WIDTH(KP_ROWS)) u_row_sync (
    .clk (clk100MHz),
    .rst (rst),
    .d   (row_in),
    .q   (rs)
  );

  // Free-running dwell counter; rows are only judged on the last cycle of each dwell.
  always_comb begin
    tick       = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick ? '0 : (tick_cnt_q + TICK_ONE);
  end

  // Scan / debounce / hold sequencing, accept side effects and entry register update.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    pat_d       = pat_q;
    dbc_d       = dbc_q;
    key_valid_d = 1'b0;
    key_code_d  = key_code_q;
    key_held_d  = key_held_q;
    entry_d     = entry_q;
    accept      = 1'b0;
    dbc_inc     = dbc_q + DB_ONE;

    unique case (state_q)
      KP_SCAN: begin
        if (tick) begin
          if (one_low(rs)) begin
            pat_d   = rs;
            dbc_d   = DB_ONE;
            state_d = KP_DEBOUNCE;
            accept  = (DB_ONE >= DB_DONE);
          end else begin
            col_d = col_q + 2'd1;
          end
        end
      end
      KP_DEBOUNCE: begin
        if (tick) begin
          if (rs == pat_q) begin
            dbc_d  = dbc_inc;
            accept = (dbc_inc >= DB_DONE);
          end else begin
            dbc_d   = '0;
            col_d   = col_q + 2'd1;
            state_d = KP_SCAN;
          end
        end
      end
      KP_HELD: begin
        // Column stays frozen, so only this column's keys can hold the release off.
        if (tick) begin
          if (rs == 4'hF) begin
            dbc_d = dbc_inc;
            if (dbc_inc >= DB_DONE) begin
              dbc_d      = '0;
              key_held_d = 1'b0;
              col_d      = col_q + 2'd1;
              state_d    = KP_SCAN;
            end
          end else begin
            dbc_d = '0;
          end
        end
      end
      default: begin
        state_d = KP_SCAN;
      end
    endcase

    if (accept) begin
      key_valid_d = 1'b1;
      key_code_d  = key_lookup(low_index(rs), col_q);
      entry_d     = {entry_q[11:0], key_code_d};
      key_held_d  = 1'b1;
      dbc_d       = '0;
      state_d     = KP_HELD;
    end

    // A clear in the accept cycle still empties the register.
    if (entry_clr) begin
      entry_d = '0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk100MHz or posedge rst) begin
    if (rst) begin
      tick_cnt_q  <= '0;
      state_q     <= KP_SCAN;
      col_q       <= 2'd0;
      pat_q       <= 4'hF;
      dbc_q       <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'h0;
      key_held_q  <= 1'b0;
      entry_q     <= 16'h0;
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      state_q     <= state_d;
      col_q       <= col_d;
      pat_q       <= pat_d;
      dbc_q       <= dbc_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      key_held_q  <= key_held_d;
      entry_q     <= entry_d;
    end
  end

  assign col_out     = ~(4'b0001 << col_q);
  assign key_valid   = key_valid_q;
  assign key_code    = key_code_q;
  assign key_held    = key_held_q;
  assign entry_value = entry_q;

endmodule

// File: tb/tb_hex_keypad_scanner.sv
// Purpose: self-checking bench for hex_keypad_scanner with a tick-level behavioural keypad model.
// Latency: model predicts every output per cycle; literal checks pin key scenarios.
// Backpressure: n/a.
module tb_hex_keypad_scanner;

  localparam int SD = 4;
  localparam int DT = 3;

  logic        clk100MHz = 1'b0;
  logic        rst = 1'b0;
  logic        entry_clr = 1'b0;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_held;
  logic [15:0] entry_value;
  logic [15:0] pressed = 16'h0;

  int tests = 0;
  int fails = 0;
  int kv_count = 0;

  string keymap = "123A456B789CE0FD";

  // Behavioural model state
  int         m_phase;
  int         m_mode;
  int         m_col;
  int         m_run;
  logic [3:0] m_h1, m_h2, m_pat, m_code;
  logic       m_kv, m_held, m_accept_next;
  logic [3:0] m_digits[$];

  int         seq_idx [5] = '{0, 1, 2, 3, 8};
  logic [15:0] seq_exp [5] = '{16'h0001, 16'h0012, 16'h0123, 16'h123A, 16'h23A7};

  always #5 clk100MHz = ~clk100MHz;

  hex_keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_TICKS(DT)) dut (
    .clk100MHz   (clk100MHz),
    .rst         (rst),
    .row_in      (row_in),
    .entry_clr   (entry_clr),
    .col_out     (col_out),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .key_held    (key_held),
    .entry_value (entry_value)
  );

  // Keypad: a pressed key shorts its row low while its column is driven low.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
  end

  function automatic logic [3:0] keypad_rows(input logic [15:0] keys, input int col);
    logic [3:0] rows;
    rows = 4'hF;
    for (int r = 0; r < 4; r++)
      if (keys[r*4+col]) rows[r] = 1'b0;
    return rows;
  endfunction

  function automatic int single_low(input logic [3:0] v);
    int n, r;
    n = 0;
    r = -1;
    for (int i = 0; i < 4; i++)
      if (!v[i]) begin
        n++;
        r = i;
      end
    return (n == 1) ? r : -1;
  endfunction

  function automatic logic [3:0] hexval(input byte ch);
    if (ch >= 8'h41) return 4'(ch - 8'h37);
    return 4'(ch - 8'h30);
  endfunction

  function automatic logic [15:0] model_entry();
    logic [15:0] e;
    e = 16'h0;
    foreach (m_digits[i]) e = {e[11:0], m_digits[i]};
    return e;
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_mode = 0;
    m_col = 0;
    m_run = 0;
    m_h1 = 4'hF;
    m_h2 = 4'hF;
    m_pat = 4'hF;
    m_code = 4'h0;
    m_kv = 1'b0;
    m_held = 1'b0;
    m_accept_next = 1'b0;
    m_digits.delete();
  endtask

  task automatic model_accept(input int row);
    m_kv = 1'b1;
    m_code = hexval(keymap[row*4+m_col]);
    m_digits.push_back(m_code);
    if (m_digits.size() > 4) void'(m_digits.pop_front());
    m_held = 1'b1;
    m_run = 0;
    m_mode = 2;
  endtask

  // One clock edge of the keypad's visible behaviour: mode 0 looking, 1 confirming, 2 waiting release.
  task automatic model_step();
    logic [3:0] rs;
    logic [3:0] now_rows;
    int row;
    bit tick;
    now_rows = keypad_rows(pressed, m_col);
    rs = m_h2;
    m_h2 = m_h1;
    m_h1 = now_rows;
    tick = (m_phase == SD - 1);
    m_phase = (m_phase + 1) % SD;
    m_kv = 1'b0;
    if (tick) begin
      row = single_low(rs);
      case (m_mode)
        0: begin
          if (row >= 0) begin
            m_pat = rs;
            m_run = 1;
            m_mode = 1;
            if (m_run >= DT) model_accept(row);
          end else begin
            m_col = (m_col + 1) % 4;
          end
        end
        1: begin
          if (rs == m_pat) begin
            m_run++;
            if (m_run >= DT) model_accept(row);
          end else begin
            m_run = 0;
            m_mode = 0;
            m_col = (m_col + 1) % 4;
          end
        end
        default: begin
          if (rs == 4'hF) m_run++;
          else m_run = 0;
          if (m_run >= DT) begin
            m_held = 1'b0;
            m_run = 0;
            m_mode = 0;
            m_col = (m_col + 1) % 4;
          end
        end
      endcase
    end
    if (entry_clr) m_digits.delete();
    m_accept_next = (m_mode == 1) && (m_run == DT - 1) && (m_phase == SD - 1) && (m_h2 == m_pat);
  endtask

  // Model advances on every clock edge and snaps back on reset.
  initial begin
    model_reset();
    forever begin
      @(posedge clk100MHz or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  // Per-cycle comparison of all outputs against the model.
  initial begin
    logic prev_kv;
    logic [3:0] exp_col;
    logic [15:0] exp_entry;
    prev_kv = 1'b0;
    forever begin
      @(negedge clk100MHz);
      exp_col = 4'hF;
      exp_col[m_col] = 1'b0;
      exp_entry = model_entry();
      tests++;
      if (col_out !== exp_col || key_valid !== m_kv || key_code !== m_code ||
          key_held !== m_held || entry_value !== exp_entry) begin
        fails++;
        $display("FAIL cycle_compare t=%0t got col=%b kv=%b code=%h held=%b entry=%h expected col=%b kv=%b code=%h held=%b entry=%h",
                 $time, col_out, key_valid, key_code, key_held, entry_value,
                 exp_col, m_kv, m_code, m_held, exp_entry);
      end
      tests++;
      if (key_valid === 1'b1 && prev_kv === 1'b1) begin
        fails++;
        $display("FAIL kv_back_to_back t=%0t got two consecutive pulses expected single", $time);
      end
      if (key_valid === 1'b1) kv_count++;
      prev_kv = key_valid;
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk100MHz);
  endtask

  task automatic wait_ticks(input int n);
    wait_cycles(n * SD);
  endtask

  task automatic pulse_clr();
    entry_clr = 1'b1;
    @(negedge clk100MHz);
    entry_clr = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int k;
    int k2;
    bit found;

    #1 rst = 1'b1;
    wait_cycles(3);
    rst = 1'b0;

    // Reset in the middle of debouncing key "1"
    pressed = 16'h1 << 0;
    wait_cycles(9);
    #1 rst = 1'b1;
    #1;
    check("rst_col_out", {12'h0, col_out}, 16'h000E);
    check("rst_key_valid", {15'h0, key_valid}, 16'h0);
    check("rst_key_held", {15'h0, key_held}, 16'h0);
    check("rst_entry", entry_value, 16'h0000);
    pressed = 16'h0;
    wait_cycles(2);
    rst = 1'b0;
    wait_ticks(10);
    check("rst_no_pulse", 16'(kv_count), 16'd0);

    // Key "5" held 20 ticks then released
    base = kv_count;
    pressed = 16'h1 << 5;
    wait_ticks(20);
    check("k5_pulses", 16'(kv_count - base), 16'd1);
    check("k5_code", {12'h0, key_code}, 16'h0005);
    check("k5_held", {15'h0, key_held}, 16'h1);
    check("k5_entry", entry_value, 16'h0005);
    pressed = 16'h0;
    wait_ticks(1);
    check("k5_held_release_pending", {15'h0, key_held}, 16'h1);
    wait_ticks(5);
    check("k5_released", {15'h0, key_held}, 16'h0);

    // Digit entry 1,2,3,A,7
    pulse_clr();
    for (int i = 0; i < 5; i++) begin
      pressed = 16'h1 << seq_idx[i];
      wait_ticks(12);
      pressed = 16'h0;
      wait_ticks(6);
      check("seq_entry", entry_value, seq_exp[i]);
    end

    // Key "8" bouncing, then stable
    base = kv_count;
    repeat (5) begin
      pressed = 16'h1 << 9;
      wait_ticks(2);
      pressed = 16'h0;
      wait_ticks(1);
    end
    check("bounce_no_pulse", 16'(kv_count - base), 16'd0);
    pressed = 16'h1 << 9;
    wait_ticks(15);
    check("bounce_pulses", 16'(kv_count - base), 16'd1);
    check("bounce_code", {12'h0, key_code}, 16'h0008);
    pressed = 16'h0;
    wait_ticks(6);

    // Ghost: "4" and "7" together, then "7" released
    base = kv_count;
    pressed = (16'h1 << 4) | (16'h1 << 8);
    wait_ticks(12);
    check("ghost_no_pulse", 16'(kv_count - base), 16'd0);
    pressed = 16'h1 << 4;
    wait_ticks(15);
    check("ghost_pulses", 16'(kv_count - base), 16'd1);
    check("ghost_code", {12'h0, key_code}, 16'h0004);
    pressed = 16'h0;
    wait_ticks(6);
    check("pre_clr_entry", entry_value, 16'hA784);

    // Clear coinciding with the accept of "F"
    pressed = 16'h1 << 14;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk100MHz);
      if (m_accept_next) begin
        found = 1'b1;
        break;
      end
    end
    check("clr_accept_found", {15'h0, found}, 16'h1);
    entry_clr = 1'b1;
    @(negedge clk100MHz);
    entry_clr = 1'b0;
    check("clr_kv", {15'h0, key_valid}, 16'h1);
    check("clr_code", {12'h0, key_code}, 16'h000F);
    check("clr_entry", entry_value, 16'h0000);
    pressed = 16'h0;
    wait_ticks(6);

    // Randomised presses, bounces, ghost pairs and clears
    for (int it = 0; it < 30; it++) begin
      k = $urandom_range(0, 15);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          pressed = 16'h1 << k;
          wait_cycles($urandom_range(2, 9));
          pressed = 16'h0;
          wait_cycles($urandom_range(1, 5));
        end
      end
      pressed = 16'h1 << k;
      if ($urandom_range(0, 4) == 0) begin
        k2 = $urandom_range(0, 15);
        pressed[k2] = 1'b1;
      end
      wait_cycles($urandom_range(8, 70));
      if ($urandom_range(0, 3) == 0) pulse_clr();
      wait_cycles($urandom_range(0, 10));
      pressed = 16'h0;
      wait_cycles($urandom_range(4, 40));
    end

    wait_ticks(8);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
